vote_tx: RTL and testbench
==========================

# vote_tx

Ballot transmitter for the voting subsystem. It captures one complete ballot in a single load handshake: 32 ordinary-voter bits, 8 VIP bits and 1 VVIP bit. It then streams the ballot out one vote token per accepted cycle over a valid/ready link to the downstream tally logic. Each token is tagged with its voter class and frame position so the receiving end can rebuild the weighted count.

## Interface
- NP_W, 32, number of ordinary-voter bits per ballot
- VIP_W, 8, number of VIP bits per ballot
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ld_valid  in  1  ballot present on np/vip/vvip
- ld_ready  out  1  block can accept a ballot (high only in IDLE)
- np  in  NP_W  ordinary votes; sampled only on the load handshake
- vip  in  VIP_W  VIP votes; sampled only on the load handshake
- vvip  in  1  VVIP vote; sampled only on the load handshake
- tx_valid  out  1  a token is presented
- tx_ready  in  1  downstream accepts the token
- tx_bit  out  1  vote value of the current token
- tx_cls  out  2  voter class: 00 = np, 01 = vip, 10 = vvip (11 is never driven)
- tx_last  out  1  current token is the final token of the frame
- ones_sent  out  7  number of accepted tokens with tx_bit = 1 in the current frame
- done  out  1  one-cycle pulse after the last token is accepted

## Operation
- Frame length FRAME_LEN = NP_W + VIP_W + 1 = 41 tokens. Fixed order:
  - np[NP_W-1] down to np[0]
  - then vip[VIP_W-1] down to vip[0]
  - then vvip
- FSM states:
  - IDLE: ld_ready = 1, tx_valid = 0.
  - SEND: ld_ready = 0, tx_valid = 1.
- Transitions:
  - IDLE to SEND: on ld_valid && ld_ready. The ballot is copied into internal registers, the token index is set to 0 and ones_sent is cleared to 0.
  - SEND to IDLE: on tx_valid && tx_ready while tx_last = 1. done is asserted for the following cycle.
- Token handshake: a token is transferred on a cycle with tx_valid && tx_ready.
  - The index increments by 1.
  - ones_sent increments by tx_bit; it saturates naturally, since the maximum is 41 < 128.
- Stability: while tx_valid = 1 and tx_ready = 0, tx_bit, tx_cls, tx_last and ones_sent hold their values.
- tx_last = 1 exactly when index = FRAME_LEN-1.
- tx_cls is decoded from the index:
  - index < NP_W → 00
  - index < NP_W+VIP_W → 01
  - otherwise → 10
- ones_sent keeps its final value in IDLE until the next load. This lets software read the frame popcount.
- Input rules:
  - ld_valid is ignored in SEND.
  - np/vip/vvip changes after the load handshake have no effect on the frame in flight.
- Reset values: IDLE, ld_ready = 1, tx_valid = 0, tx_bit = 0, tx_cls = 00, tx_last = 0, ones_sent = 0, done = 0, index = 0.
- Reset mid-frame: immediate asynchronous return to the reset values. The partial frame is abandoned and no done pulse is produced.

## Timing
- Load handshake at edge N: tx_valid = 1 with token 0 (np[31]) is visible from edge N+1.
- With tx_ready held at 1, one token is transferred per cycle.
  - The whole frame takes 41 cycles.
  - The last transfer at edge M gives state IDLE, ld_ready = 1 and done = 1 from edge M+1.
  - done drops at edge M+2.
- Earliest next load is at edge M+1, so there is a minimum one-cycle gap between frames.
- All outputs are registered or decoded only from registered state. There is no combinational path from tx_ready or ld_valid to any output.

## Structure
- A shared vote package holds:
  - class encodings CLS_NP, CLS_VIP, CLS_VVIP
  - default widths NP_W/VIP_W
  - FRAME_LEN
  - the state encoding IDLE/SEND
- One sub-module, vote_tx_shreg: a FRAME_LEN-bit load/shift register.
  - Parallel load is {np, vip, vvip}, MSB first.
  - It shifts left on a token handshake; its MSB drives tx_bit.
- The top level holds the FSM, the index counter, the class decode and ones_sent.

## Test plan
- Basic frame: load np = 32'hFFFF_0000, vip = 8'hA5, vvip = 1, tx_ready = 1.
  - Expect 41 tokens in order: 16×1, then 16×0 with cls 00, then 1,0,1,0,0,1,0,1 with cls 01, then 1 with cls 10 and tx_last.
  - Expect ones_sent = 21 and done high for one cycle.
- Backpressure: same ballot with tx_ready toggling at random.
  - Expect identical token sequence.
  - Outputs hold steady on every stall cycle; ones_sent = 21.
- Load gating: assert ld_valid with a different ballot mid-frame.
  - Expect ld_ready = 0 and the frame unchanged.
  - Expect the new ballot accepted the cycle after done.
- Zero and full ballots:
  - All zeros: ones_sent = 0.
  - All ones: ones_sent = 41, tx_last only on token 40.
- Async reset: drop rst_n at token 10 while tx_ready = 0.
  - Expect tx_valid = 0, ld_ready = 1, ones_sent = 0 immediately and no done pulse.
  - A new load after release restarts at np[31].

Source files
------------

// File: rtl/vote_tx_pkg.sv
// Shared definitions for the ballot transmitter: voter-class codes, default
// ballot widths, frame length and the FSM state encoding.
package vote_tx_pkg;

  localparam int NP_W_DFLT  = 32;
  localparam int VIP_W_DFLT = 8;
  localparam int FRAME_LEN  = NP_W_DFLT + VIP_W_DFLT + 1;

  typedef enum logic [1:0] {
    CLS_NP   = 2'b00,
    CLS_VIP  = 2'b01,
    CLS_VVIP = 2'b10
  } cls_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/vote_tx_shreg.sv
// Frame shift register: parallel load of the whole ballot, MSB first, then
// shift left one position per accepted token. The MSB is the current token.
module vote_tx_shreg #(
  parameter int W = vote_tx_pkg::FRAME_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sh_q;

  // Load has priority; a shift moves the next token into the MSB.
  // NOTE: this is a plain register, not a memory, so it takes the async reset
  // and the current token reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= data_i;
    end else if (shift_i) begin
      sh_q <= {sh_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sh_q[W-1];

endmodule

// File: rtl/vote_tx.sv
// Ballot transmitter: captures {np, vip, vvip} on a load handshake, then
// streams one tagged token per accepted cycle over a valid/ready link.
// Every output comes from registered state only.
module vote_tx
  import vote_tx_pkg::*;
#(
  parameter int NP_W  = NP_W_DFLT,
  parameter int VIP_W = VIP_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [NP_W-1:0]  np,
  input  logic [VIP_W-1:0] vip,
  input  logic             vvip,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_bit,
  output logic [1:0]       tx_cls,
  output logic             tx_last,
  output logic [6:0]       ones_sent,
  output logic             done
);

  localparam int FLEN  = NP_W + VIP_W + 1;
  localparam int IDX_W = $clog2(FLEN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]       ones_q, ones_d;
  logic             done_q, done_d;
  logic             load, shift;
  cls_e             cls;

  vote_tx_shreg #(.W(FLEN)) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .shift_i(shift),
    .data_i ({np, vip, vvip}),
    .msb_o  (tx_bit)
  );

  // State, index, popcount and done registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load in IDLE, advance one token per handshake in SEND.
  // The index returns to 0 with the last token so IDLE decodes as class np.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          load    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
          ones_d  = '0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          shift  = 1'b1;
          ones_d = ones_q + 7'(tx_bit);
          if (tx_last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Voter class decoded from the token position.
  always_comb begin
    if (idx_q < IDX_W'(NP_W))              cls = CLS_NP;
    else if (idx_q < IDX_W'(NP_W + VIP_W)) cls = CLS_VIP;
    else                                    cls = CLS_VVIP;
  end

  assign ld_ready  = (state_q == IDLE);
  assign tx_valid  = (state_q == SEND);
  assign tx_cls    = cls;
  assign tx_last   = (idx_q == IDX_W'(FLEN - 1));
  assign ones_sent = ones_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vote_tx.sv
// Self-checking bench for vote_tx: expected tokens are queued when a ballot
// is loaded and popped as the DUT transfers them.
module tb_vote_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] np = '0;
  logic [7:0]  vip = '0;
  logic        vvip = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_bit;
  logic [1:0]  tx_cls;
  logic        tx_last;
  logic [6:0]  ones_sent;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected token: {bit, cls[1:0], last}
  logic [3:0] exp_q[$];

  vote_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .np       (np),
    .vip      (vip),
    .vvip     (vvip),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_bit   (tx_bit),
    .tx_cls   (tx_cls),
    .tx_last  (tx_last),
    .ones_sent(ones_sent),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cls_of(input int i);
    if (i < 32) return 2'b00;
    if (i < 40) return 2'b01;
    return 2'b10;
  endfunction

  task automatic push_frame(input logic [40:0] f);
    for (int i = 0; i < 41; i++)
      exp_q.push_back({f[40-i], cls_of(i), (i == 40)});
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the load edge.
  task automatic load_ballot(input logic [31:0] a, input logic [7:0] b, input logic c);
    np = a; vip = b; vvip = c; ld_valid = 1'b1;
    push_frame({a, b, c});
    @(negedge clk);
    ld_valid = 1'b0;
    n_cmp++;
    if ({tx_valid, ld_ready, ones_sent, done} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL load_state: got valid=%b ready=%b ones=%0d done=%b, want 1 0 0 0",
               tx_valid, ld_ready, ones_sent, done);
    end
  endtask

  // Streams queued tokens. stop_at >= 0 returns with that token presented and
  // tx_ready low. gate drives a different ballot onto the load port mid-frame.
  task automatic stream(input int stall_pct, input int stop_at, input bit gate,
                        input logic [40:0] alt, input int want_ones);
    int acc = 0;
    int cnt = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [10:0] prev = '0;
    logic [3:0] e;
    while (acc < 41) begin
      if (++cyc > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_timeout: got %0d tokens, want 41", acc);
        exp_q.delete();
        tx_ready = 1'b0;
        return;
      end
      if (gate && acc == 5 && !ld_valid) begin
        {np, vip, vvip} = alt;
        ld_valid = 1'b1;
      end
      e = (exp_q.size() > 0) ? exp_q[0] : 4'hx;
      n_cmp++;
      if ({tx_valid, tx_bit, tx_cls, tx_last} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL token%0d: got valid=%b bit=%b cls=%b last=%b, want 1 %b %b %b",
                 acc, tx_valid, tx_bit, tx_cls, tx_last, e[3], e[2:1], e[0]);
      end
      n_cmp++;
      if (ones_sent !== 7'(cnt)) begin
        n_bad++;
        $display("FAIL ones_run%0d: got %0d, want %0d", acc, ones_sent, cnt);
      end
      if (stalled) begin
        n_cmp++;
        if ({tx_bit, tx_cls, tx_last, ones_sent} !== prev) begin
          n_bad++;
          $display("FAIL stall_hold%0d: got %h, want %h", acc,
                   {tx_bit, tx_cls, tx_last, ones_sent}, prev);
        end
      end
      if (ld_valid) begin
        n_cmp++;
        if (ld_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL ld_gate%0d: got ld_ready=%b, want 0", acc, ld_ready);
        end
      end
      if (stop_at == acc) begin
        tx_ready = 1'b0;
        return;
      end
      tx_ready = ($urandom_range(99) >= stall_pct);
      stalled  = !tx_ready;
      prev     = {tx_bit, tx_cls, tx_last, ones_sent};
      if (tx_ready) begin
        acc++;
        cnt += int'(e[3]);
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_cmp++;
    if ({done, tx_valid, ld_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL frame_end: got done=%b valid=%b ready=%b, want 1 0 1",
               done, tx_valid, ld_ready);
    end
    n_cmp++;
    if (ones_sent !== 7'(want_ones)) begin
      n_bad++;
      $display("FAIL ones_final: got %0d, want %0d", ones_sent, want_ones);
    end
  endtask

  task automatic check_done_drop(input logic want_valid);
    @(negedge clk);
    n_cmp++;
    if ({done, tx_valid} !== {1'b0, want_valid}) begin
      n_bad++;
      $display("FAIL done_drop: got done=%b valid=%b, want 0 %b", done, tx_valid, want_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ld_ready, tx_valid, tx_bit, tx_cls, tx_last, ones_sent, done} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 7'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: got rdy=%b vld=%b bit=%b cls=%b last=%b ones=%0d done=%b",
               ld_ready, tx_valid, tx_bit, tx_cls, tx_last, ones_sent, done);
    end
  endtask

  task automatic test_basic();
    load_ballot(32'hFFFF_0000, 8'hA5, 1'b1);
    stream(0, -1, 1'b0, '0, 21);
    check_done_drop(1'b0);
  endtask

  task automatic test_backpressure();
    load_ballot(32'hFFFF_0000, 8'hA5, 1'b1);
    stream(50, -1, 1'b0, '0, 21);
    check_done_drop(1'b0);
  endtask

  task automatic test_load_gating();
    logic [40:0] alt;
    alt = {32'h0000_00F0, 8'h0F, 1'b0};
    load_ballot(32'hFFFF_0000, 8'hA5, 1'b1);
    stream(30, -1, 1'b1, alt, 21);
    // ld_valid is still high: the new ballot loads on the done cycle's edge.
    push_frame(alt);
    @(negedge clk);
    ld_valid = 1'b0;
    n_cmp++;
    if ({done, tx_valid, ld_ready, ones_sent} !== {1'b0, 1'b1, 1'b0, 7'd0}) begin
      n_bad++;
      $display("FAIL gate_reload: got done=%b valid=%b ready=%b ones=%0d, want 0 1 0 0",
               done, tx_valid, ld_ready, ones_sent);
    end
    stream(0, -1, 1'b0, '0, 8);
    check_done_drop(1'b0);
  endtask

  task automatic test_zero_full();
    load_ballot('0, '0, 1'b0);
    stream(20, -1, 1'b0, '0, 0);
    check_done_drop(1'b0);
    load_ballot('1, '1, 1'b1);
    stream(20, -1, 1'b0, '0, 41);
    check_done_drop(1'b0);
  endtask

  task automatic test_async_reset();
    load_ballot(32'h8000_0001, 8'h81, 1'b1);
    stream(0, 10, 1'b0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, ld_ready, ones_sent, done, tx_last, tx_cls} !== {1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL async_reset: got vld=%b rdy=%b ones=%0d done=%b last=%b cls=%b",
               tx_valid, ld_ready, ones_sent, done, tx_last, tx_cls);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, tx_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL no_done_after_reset%0d: got done=%b valid=%b, want 0 0", i, done, tx_valid);
      end
    end
    load_ballot(32'h8000_0000, 8'h00, 1'b0);
    stream(10, -1, 1'b0, '0, 1);
    check_done_drop(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_gating();
    test_zero_full();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
